// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path:
// FSM states, opcodes, ALU operations and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] opcode);
        logic legal;
        case (opcode)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: fixed add/sub for address and branch
// states, funct3/funct7 decode for R-type and I-type ALU instructions.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) may select sub; addi ignores bit 30.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing the shared-memory
// datapath, stalling on mem_ready, plus the ImmSrc decode.
module mc_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        illegal_instr
);

    state_t state_reg;
    state_t state_next;
    state_t out_state;
    aluop_t alu_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // While reset is held, present FETCH selects regardless of the stored state.
    assign out_state = reset ? state_reg : S_FETCH;

    always_comb begin
        PCWrite       = 1'b0;
        AdrSrc        = ADR_PC;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (out_state)
            S_FETCH: begin
                AdrSrc    = ADR_PC;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready & reset;
                PCWrite   = mem_ready & reset;
            end
            S_DECODE: begin
                ALUSrcA       = SRCA_OLDPC;
                ALUSrcB       = SRCB_IMM;
                illegal_instr = ~is_legal_op(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = ADR_RESULT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = ADR_RESULT;
                MemWrite  = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = Zero;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule
